// File: rtl/veer_types.sv
// Shared types for the decode-side instruction FIFO sequencer.
package veer_types;

  typedef enum logic [1:0] {
    IB_BYPASS,
    IB_DRAIN,
    IB_FLUSH
  } ib_fifo_state_e;

  localparam int IB_FIFO_DEPTH = 8;

  function automatic logic [3:0] ib_valid_therm(input int unsigned n);
    if (n >= 4) return 4'b1111;
    if (n == 3) return 4'b0111;
    if (n == 2) return 4'b0011;
    if (n == 1) return 4'b0001;
    return 4'b0000;
  endfunction

endpackage

// File: rtl/dec_ib_ptr.sv
// Modulo pointer for the ib FIFO: advances by 0/1/2, wraps naturally.
module dec_ib_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             clr,
  input  logic [1:0]       inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else begin
      ptr <= ptr + PTR_W'(inc);
    end
  end

endmodule

// File: rtl/dec_ib_fifo_ctl.sv
// Bypass/queue sequencer for the decode instruction FIFO beside the ib buffer.
module dec_ib_fifo_ctl
  import veer_types::*;
#(
  parameter int DEPTH = IB_FIFO_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             exu_flush_final,
  input  logic             ifu_i0_valid,
  input  logic             ifu_i1_valid,
  input  logic             dec_stall_d,
  input  logic             dec_i0_decode_d,
  input  logic             dec_i1_decode_d,
  output logic [1:0]       fifo_wr_en,
  output logic [PTR_W-1:0] fifo_wr_ptr,
  output logic [PTR_W-1:0] fifo_rd_ptr,
  output logic             i0_rd_enable_next,
  output logic [3:0]       dec_ib_valid_fifo,
  output logic [PTR_W:0]   fifo_count,
  output logic             ifu_ib_stall,
  output logic             fifo_overflow
);

  localparam logic [PTR_W:0] FULL     = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] STALL_AT = (PTR_W+1)'(DEPTH - 1);

  ib_fifo_state_e state;
  ib_fifo_state_e state_nxt;

  logic [1:0]     push_n;
  logic [1:0]     pop_req;
  logic [1:0]     pop_n;
  logic [1:0]     acc_n;
  logic [PTR_W:0] room;
  logic [PTR_W:0] count_nxt;
  logic           to_fifo;
  logic           drop;

  assign push_n  = {1'b0, ifu_i0_valid}
                 + {1'b0, ifu_i0_valid & ifu_i1_valid};
  assign pop_req = {1'b0, dec_i0_decode_d}
                 + {1'b0, dec_i0_decode_d & dec_i1_decode_d};

  always_comb begin
    state_nxt = state;
    to_fifo   = 1'b0;
    pop_n     = 2'd0;
    unique case (state)
      IB_BYPASS: begin
        to_fifo = dec_stall_d && (push_n != 2'd0);
        if (to_fifo) state_nxt = IB_DRAIN;
      end
      IB_DRAIN: begin
        to_fifo = 1'b1;
        pop_n   = ((PTR_W+1)'(pop_req) > fifo_count)
                ? fifo_count[1:0] : pop_req;
      end
      default: state_nxt = IB_BYPASS;
    endcase
    if (exu_flush_final || !rst_l) begin
      to_fifo = 1'b0;
      pop_n   = 2'd0;
    end
    // slots popped this cycle are reusable by this cycle's push
    room  = FULL - fifo_count + (PTR_W+1)'(pop_n);
    acc_n = 2'd0;
    if (to_fifo) begin
      acc_n = (room >= (PTR_W+1)'(push_n)) ? push_n : room[1:0];
    end
    drop      = to_fifo && (acc_n != push_n);
    count_nxt = fifo_count + (PTR_W+1)'(acc_n) - (PTR_W+1)'(pop_n);
    if (state == IB_DRAIN && count_nxt == '0) state_nxt = IB_BYPASS;
    if (exu_flush_final) begin
      state_nxt = IB_FLUSH;
      count_nxt = '0;
    end
  end

  assign fifo_wr_en = {acc_n == 2'd2, acc_n != 2'd0};

  dec_ib_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_l (rst_l),
    .clr   (exu_flush_final),
    .inc   (acc_n),
    .ptr   (fifo_wr_ptr)
  );

  dec_ib_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_l (rst_l),
    .clr   (exu_flush_final),
    .inc   (pop_n),
    .ptr   (fifo_rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state             <= IB_BYPASS;
      fifo_count        <= '0;
      i0_rd_enable_next <= 1'b0;
      dec_ib_valid_fifo <= 4'b0000;
      ifu_ib_stall      <= 1'b0;
      fifo_overflow     <= 1'b0;
    end else begin
      state             <= state_nxt;
      fifo_count        <= count_nxt;
      i0_rd_enable_next <= (state_nxt == IB_DRAIN);
      dec_ib_valid_fifo <= ib_valid_therm(32'(count_nxt));
      ifu_ib_stall      <= (count_nxt >= STALL_AT);
      fifo_overflow     <= !exu_flush_final && (fifo_overflow || drop);
    end
  end

endmodule

// File: tb/tb_dec_ib_fifo_ctl.sv
// Randomized and directed bench for dec_ib_fifo_ctl against a queue model.
module tb_dec_ib_fifo_ctl;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int M_BYP = 0;
  localparam int M_DRN = 1;
  localparam int M_FLS = 2;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic flush = 1'b0;
  logic i0 = 1'b0;
  logic i1 = 1'b0;
  logic stall = 1'b0;
  logic d0 = 1'b0;
  logic d1 = 1'b0;

  logic [1:0]       wr_en;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             sel;
  logic [3:0]       valid;
  logic [PTR_W:0]   count;
  logic             ib_stall;
  logic             ovf;

  int tests = 0;
  int fails = 0;

  int q[$];
  int mem[DEPTH];
  int m_wr;
  int m_rd;
  int m_mode;
  bit m_ovf;
  int next_tag = 1;

  always #5 clk = ~clk;

  dec_ib_fifo_ctl dut (
    .clk               (clk),
    .rst_l             (rst_l),
    .exu_flush_final   (flush),
    .ifu_i0_valid      (i0),
    .ifu_i1_valid      (i1),
    .dec_stall_d       (stall),
    .dec_i0_decode_d   (d0),
    .dec_i1_decode_d   (d1),
    .fifo_wr_en        (wr_en),
    .fifo_wr_ptr       (wr_ptr),
    .fifo_rd_ptr       (rd_ptr),
    .i0_rd_enable_next (sel),
    .dec_ib_valid_fifo (valid),
    .fifo_count        (count),
    .ifu_ib_stall      (ib_stall),
    .fifo_overflow     (ovf)
  );

  task automatic model_reset();
    q.delete();
    m_wr   = 0;
    m_rd   = 0;
    m_mode = M_BYP;
    m_ovf  = 1'b0;
  endtask

  task automatic run_cycle(input bit a0, a1, as, b0, b1, bf);
    int push, pop, acc, room, slot, n;
    bit to_fifo;
    logic [1:0] exp_we;
    logic [3:0] exp_valid;
    @(negedge clk);
    i0 = a0; i1 = a1; stall = as;
    d0 = b0; d1 = b1; flush = bf;
    #1;
    push = a0 ? (a1 ? 2 : 1) : 0;
    pop = 0;
    to_fifo = 1'b0;
    if (!bf) begin
      if (m_mode == M_BYP) begin
        to_fifo = as && push > 0;
      end else if (m_mode == M_DRN) begin
        to_fifo = 1'b1;
        pop = b0 ? (b1 ? 2 : 1) : 0;
        if (pop > q.size()) pop = q.size();
      end
    end
    room = DEPTH - q.size() + pop;
    acc = to_fifo ? ((push < room) ? push : room) : 0;
    exp_we = (acc == 2) ? 2'b11 : (acc == 1) ? 2'b01 : 2'b00;
    tests++;
    if (wr_en !== exp_we || wr_ptr !== PTR_W'(m_wr)) begin
      fails++;
      $display("FAIL wr_port: wr_en=%b wr_ptr=%0d, required wr_en=%b wr_ptr=%0d",
               wr_en, wr_ptr, exp_we, m_wr);
    end
    for (int k = 0; k < pop; k++) begin
      slot = (int'(rd_ptr) + k) % DEPTH;
      tests++;
      if (mem[slot] != q[k]) begin
        fails++;
        $display("FAIL read_order: slot %0d holds tag %0d, required tag %0d",
                 slot, mem[slot], q[k]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (wr_en[k] === 1'b1) mem[(int'(wr_ptr) + k) % DEPTH] = next_tag + k;
    end
    @(posedge clk);
    #1;
    if (bf) begin
      model_reset();
      m_mode = M_FLS;
    end else begin
      repeat (pop) void'(q.pop_front());
      for (int k = 0; k < acc; k++) q.push_back(next_tag + k);
      next_tag += acc;
      m_wr = (m_wr + acc) % DEPTH;
      m_rd = (m_rd + pop) % DEPTH;
      if (to_fifo && acc < push) m_ovf = 1'b1;
      if (m_mode == M_FLS) m_mode = M_BYP;
      else if (m_mode == M_BYP && to_fifo) m_mode = M_DRN;
      else if (m_mode == M_DRN && q.size() == 0) m_mode = M_BYP;
    end
    n = (q.size() > 4) ? 4 : q.size();
    exp_valid = 4'((1 << n) - 1);
    tests++;
    if (count !== (PTR_W+1)'(q.size()) || rd_ptr !== PTR_W'(m_rd) ||
        sel !== (m_mode == M_DRN) || valid !== exp_valid ||
        ib_stall !== ((DEPTH - q.size()) < 2) || ovf !== m_ovf) begin
      fails++;
      $display("FAIL regs: count=%0d rd=%0d sel=%b valid=%b stall=%b ovf=%b, required count=%0d rd=%0d sel=%b valid=%b stall=%b ovf=%b",
               count, rd_ptr, sel, valid, ib_stall, ovf, q.size(), m_rd,
               m_mode == M_DRN, exp_valid, (DEPTH - q.size()) < 2, m_ovf);
    end
  endtask

  task automatic do_flush();
    run_cycle(0, 0, 0, 0, 0, 1);
    run_cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      i0 = 1'($urandom); i1 = 1'($urandom); stall = 1'b1;
      d0 = 1'($urandom); d1 = 1'($urandom); flush = 1'b0;
      #1;
      tests++;
      if ({wr_en, wr_ptr, rd_ptr, sel, valid, count, ib_stall, ovf} !== '0) begin
        fails++;
        $display("FAIL reset: wr_en=%b wr=%0d rd=%0d sel=%b valid=%b count=%0d stall=%b ovf=%b, required all 0",
                 wr_en, wr_ptr, rd_ptr, sel, valid, count, ib_stall, ovf);
      end
    end
    @(negedge clk);
    i0 = 0; i1 = 0; stall = 0; d0 = 0; d1 = 0;
    rst_l = 1'b1;
    model_reset();
  endtask

  task automatic test_bypass();
    for (int c = 0; c < 4; c++) begin
      run_cycle(1, 1, 0, 1'($urandom), 1'($urandom), 0);
      tests++;
      if (wr_en !== 2'b00 || sel !== 1'b0 || count !== '0) begin
        fails++;
        $display("FAIL bypass: wr_en=%b sel=%b count=%0d, required 00/0/0",
                 wr_en, sel, count);
      end
    end
  endtask

  task automatic test_fill_drain();
    repeat (3) run_cycle(1, 1, 1, 0, 0, 0);
    tests++;
    if (count !== 4'd6 || sel !== 1'b1 || valid !== 4'b1111) begin
      fails++;
      $display("FAIL fill: count=%0d sel=%b valid=%b, required 6/1/1111",
               count, sel, valid);
    end
    repeat (3) run_cycle(0, 0, 1, 1, 1, 0);
    tests++;
    if (count !== '0 || sel !== 1'b0) begin
      fails++;
      $display("FAIL drain: count=%0d sel=%b, required 0/0", count, sel);
    end
  endtask

  task automatic test_wrap();
    do_flush();
    repeat (7) run_cycle(1, 0, 1, 0, 0, 0);
    repeat (7) run_cycle(0, 0, 0, 1, 0, 0);
    repeat (2) run_cycle(1, 1, 1, 0, 0, 0);
    tests++;
    if (wr_ptr !== 3'd3 || count !== 4'd4) begin
      fails++;
      $display("FAIL wrap_wr: wr_ptr=%0d count=%0d, required 3/4", wr_ptr, count);
    end
    repeat (2) run_cycle(0, 0, 0, 1, 1, 0);
    tests++;
    if (rd_ptr !== 3'd3 || count !== '0) begin
      fails++;
      $display("FAIL wrap_rd: rd_ptr=%0d count=%0d, required 3/0", rd_ptr, count);
    end
  endtask

  task automatic test_full();
    repeat (4) run_cycle(1, 1, 1, 0, 0, 0);
    tests++;
    if (count !== 4'd8 || ib_stall !== 1'b1) begin
      fails++;
      $display("FAIL full: count=%0d stall=%b, required 8/1", count, ib_stall);
    end
    run_cycle(1, 1, 1, 1, 1, 0);
    tests++;
    if (count !== 4'd8 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL full_pushpop: count=%0d ovf=%b, required 8/0", count, ovf);
    end
    run_cycle(1, 0, 1, 0, 0, 0);
    tests++;
    if (count !== 4'd8 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL overflow: count=%0d ovf=%b, required 8/1", count, ovf);
    end
    run_cycle(0, 0, 0, 0, 0, 1);
    tests++;
    if (ovf !== 1'b0 || count !== '0) begin
      fails++;
      $display("FAIL ovf_clear: ovf=%b count=%0d, required 0/0", ovf, count);
    end
    run_cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flush();
    run_cycle(1, 1, 1, 0, 0, 0);
    run_cycle(1, 1, 1, 0, 0, 0);
    run_cycle(1, 0, 1, 0, 0, 0);
    run_cycle(1, 1, 1, 0, 0, 1);
    tests++;
    if (count !== '0 || sel !== 1'b0) begin
      fails++;
      $display("FAIL flush: count=%0d sel=%b, required 0/0", count, sel);
    end
    run_cycle(1, 1, 1, 0, 0, 0);
    tests++;
    if (count !== '0 || sel !== 1'b0) begin
      fails++;
      $display("FAIL flush_state: count=%0d sel=%b, required 0/0", count, sel);
    end
    run_cycle(1, 1, 1, 0, 0, 0);
    tests++;
    if (count !== 4'd2 || sel !== 1'b1) begin
      fails++;
      $display("FAIL after_flush: count=%0d sel=%b, required 2/1", count, sel);
    end
  endtask

  task automatic test_random();
    bit a0, a1, as, b0, b1, bf;
    for (int c = 0; c < 400; c++) begin
      a0 = ($urandom_range(0, 3) != 0) &&
           (ib_stall !== 1'b1 || $urandom_range(0, 15) == 0);
      a1 = 1'($urandom);
      as = 1'($urandom);
      b0 = ($urandom_range(0, 2) != 0);
      b1 = 1'($urandom);
      bf = ($urandom_range(0, 31) == 0);
      run_cycle(a0, a1, as, b0, b1, bf);
    end
  endtask

  task automatic test_async_reset();
    do_flush();
    run_cycle(1, 1, 1, 0, 0, 0);
    run_cycle(1, 1, 1, 0, 0, 0);
    #2;
    rst_l = 1'b0;
    #1;
    tests++;
    if ({wr_en, wr_ptr, rd_ptr, sel, valid, count, ib_stall, ovf} !== '0) begin
      fails++;
      $display("FAIL async_reset: wr_en=%b wr=%0d rd=%0d sel=%b valid=%b count=%0d, required all 0",
               wr_en, wr_ptr, rd_ptr, sel, valid, count);
    end
    @(negedge clk);
    i0 = 0; i1 = 0; stall = 0; d0 = 0; d1 = 0; flush = 0;
    rst_l = 1'b1;
    model_reset();
    run_cycle(1, 0, 1, 0, 0, 0);
    run_cycle(0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bypass();
    test_fill_drain();
    test_wrap();
    test_full();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
